// File: rtl/press_classifier_pkg.sv
// Shared button package.
// Holds the constants for the debounce stage and the press classifier, the
// classifier state enumeration, and a width-check helper used at elaboration.
package press_classifier_pkg;

  // Debounce stage constants (the stage that produces bt / bt_flag)
  localparam int DB_STABLE_CYC = 16;
  localparam int DB_CNT_W      = 5;

  // Press classifier defaults
  localparam int LONG_CYC_DEF = 200;
  localparam int GAP_CYC_DEF  = 150;
  localparam int CNT_W_DEF    = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HELD1 = 3'd1,
    ST_GAP   = 3'd2,
    ST_HELD2 = 3'd3,
    ST_REL   = 3'd4
  } press_state_e;

  // True when a cnt_w-bit counter can hold every value up to max(a, b).
  function automatic bit cnt_fits(input int cnt_w, input int a, input int b);
    longint lim;
    lim = longint'(1) << cnt_w;
    return (lim > longint'(a)) && (lim > longint'(b));
  endfunction

endpackage

// File: rtl/press_classifier.sv
// press_classifier
// Classifies a debounced button into single, double and long presses.
// Sits directly after the debounce flag stage on the same clock and reset.
//
// Ports
//   clk_d    in   block clock, rising edge
//   rst      in   synchronous active-high reset
//   bt       in   debounced button level, 1 = pressed
//   bt_flag  in   one-cycle pulse, confirmed press
//   single_p out  one-cycle pulse, completed single short press
//   double_p out  one-cycle pulse, double press
//   long_p   out  one-cycle pulse, long press
//   busy     out  high while a press sequence is in progress
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int LONG_CYC = LONG_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk_d,
  input  logic rst,
  input  logic bt,
  input  logic bt_flag,
  output logic single_p,
  output logic double_p,
  output logic long_p,
  output logic busy
);

  if (!cnt_fits(CNT_W, LONG_CYC, GAP_CYC)) begin : g_cnt_w_chk
    $error("press_classifier: CNT_W too narrow for LONG_CYC/GAP_CYC");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  press_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // bt alone never starts a sequence: a press still held after reset
        // stays ignored until the debounce stage confirms a new one.
        if (bt_flag) begin
          state_d = ST_HELD1;
          cnt_d   = '0;
        end
      end
      ST_HELD1: begin
        if (!bt) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = ST_REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        // A second press on the last gap cycle still counts as a double.
        if (bt_flag) begin
          double_d = 1'b1;
          state_d  = ST_HELD2;
        end else if (cnt_q == GAP_LAST) begin
          single_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD2, ST_REL: begin
        // Further flags are ignored here, so a third press is never classified.
        if (!bt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Decoded from the next state so busy drops on the same edge the
    // sequence ends, together with any final pulse.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_d) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
    end
  end

  assign single_p = single_q;
  assign double_p = double_q;
  assign long_p   = long_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier with LONG_CYC=8, GAP_CYC=6.
// Outputs are compared every cycle, #1 after the rising edge, as the
// vector {single_p, double_p, long_p, busy}.
module tb_press_classifier;

  localparam int LONG_CYC = 8;
  localparam int GAP_CYC  = 6;
  localparam int CNT_W    = 4;

  logic clk_d = 1'b0;
  logic rst, bt, bt_flag;
  logic single_p, double_p, long_p, busy;

  always #5 clk_d = ~clk_d;

  press_classifier #(
    .LONG_CYC (LONG_CYC),
    .GAP_CYC  (GAP_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_d    (clk_d),
    .rst      (rst),
    .bt       (bt),
    .bt_flag  (bt_flag),
    .single_p (single_p),
    .double_p (double_p),
    .long_p   (long_p),
    .busy     (busy)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_s, n_d, n_l;

  // Reference model: time-stamp based. phase 0 = idle, 1 = first press held,
  // 2 = waiting for a second press, 3 = sequence decided, waiting for release.
  int          m_phase = 0;
  int          m_t0    = 0;
  int          m_cyc   = 0;
  logic [3:0]  exp_vec = 4'b0;

  task automatic model_edge(input logic r, input logic b, input logic f);
    logic es, ed, el;
    es = 1'b0; ed = 1'b0; el = 1'b0;
    m_cyc++;
    if (r) m_phase = 0;
    else begin
      case (m_phase)
        0: if (f) begin m_phase = 1; m_t0 = m_cyc; end
        1: begin
          if (b && (m_cyc - m_t0 == LONG_CYC)) begin el = 1'b1; m_phase = 3; end
          else if (!b) begin m_phase = 2; m_t0 = m_cyc; end
        end
        2: begin
          if (f) begin ed = 1'b1; m_phase = 3; end
          else if (m_cyc - m_t0 == GAP_CYC) begin es = 1'b1; m_phase = 0; end
        end
        default: if (!b) m_phase = 0;
      endcase
    end
    exp_vec = r ? 4'b0 : {es, ed, el, (m_phase != 0)};
  endtask

  function automatic logic [3:0] outs();
    return {single_p, double_p, long_p, busy};
  endfunction

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b expected=%b (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic step(input logic r, input logic b, input logic f, input string nm);
    rst = r; bt = b; bt_flag = f;
    @(posedge clk_d);
    model_edge(r, b, f);
    #1;
    check(nm, outs(), exp_vec);
    n_s += int'(single_p);
    n_d += int'(double_p);
    n_l += int'(long_p);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, "idle");
    n_s = 0; n_d = 0; n_l = 0;
  endtask

  typedef struct {
    logic       r;
    logic       b;
    logic       f;
    logic [3:0] exp;   // {single, double, long, busy}
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic b, input logic f, input logic [3:0] e);
    vec_t v;
    v.r = r; v.b = b; v.f = f; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; bt = 1'b0; bt_flag = 1'b0;
    n_s = 0; n_d = 0; n_l = 0;

    // ---- table: reset, single press, long press ----
    add(1, 0, 1, 4'b0000);                         // reset wins over flag
    add(1, 0, 0, 4'b0000);
    // single: bt high 3 cycles, release, single_p 6 cycles after release
    add(0, 1, 1, 4'b0001);
    add(0, 1, 0, 4'b0001);
    add(0, 1, 0, 4'b0001);
    add(0, 0, 0, 4'b0001);                         // release edge
    for (int i = 0; i < 5; i++) add(0, 0, 0, 4'b0001);
    add(0, 0, 0, 4'b1000);                         // single, busy falls
    add(0, 0, 0, 4'b0000);
    // long: held 20 cycles, long_p 8 cycles after flag
    add(0, 1, 1, 4'b0001);
    for (int i = 0; i < 7; i++) add(0, 1, 0, 4'b0001);
    add(0, 1, 0, 4'b0011);                         // long
    for (int i = 0; i < 11; i++) add(0, 1, 0, 4'b0001);
    add(0, 0, 0, 4'b0000);                         // release + 1
    add(0, 0, 0, 4'b0000);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].b, tbl[i].f, "tbl_model");
      check($sformatf("tbl[%0d]", i), outs(), tbl[i].exp);
    end

    // ---- double press ----
    idle_n(2);
    step(0, 1, 1, "dbl"); step(0, 1, 0, "dbl");
    for (int i = 0; i < 3; i++) step(0, 0, 0, "dbl");
    step(0, 1, 1, "dbl");
    check("dbl_pulse", outs(), 4'b0101);
    step(0, 1, 0, "dbl");
    for (int i = 0; i < 10; i++) step(0, 0, 0, "dbl");
    check("dbl_counts", {n_s[1:0], n_d[1:0]}, 4'b0001);

    // ---- gap boundary: flag on 6th gap cycle -> double only ----
    idle_n(2);
    step(0, 1, 1, "gapA"); step(0, 0, 0, "gapA");
    for (int i = 0; i < 5; i++) step(0, 0, 0, "gapA");
    step(0, 1, 1, "gapA");
    check("gap6_double", outs(), 4'b0101);
    step(0, 0, 0, "gapA");
    for (int i = 0; i < 10; i++) step(0, 0, 0, "gapA");
    check("gap6_counts", {n_s[1:0], n_d[1:0]}, 4'b0001);

    // ---- gap boundary: flag on 7th gap cycle -> single, then new sequence ----
    idle_n(2);
    step(0, 1, 1, "gapB"); step(0, 0, 0, "gapB");
    for (int i = 0; i < 5; i++) step(0, 0, 0, "gapB");
    step(0, 0, 0, "gapB");
    check("gap7_single", outs(), 4'b1000);
    step(0, 1, 1, "gapB");
    check("gap7_restart", outs(), 4'b0001);
    step(0, 0, 0, "gapB");
    for (int i = 0; i < 6; i++) step(0, 0, 0, "gapB");
    check("gap7_counts", {n_s[1:0], n_d[1:0]}, 4'b1000);

    // ---- reset in HELD1 at count 5, press still held ----
    idle_n(2);
    step(0, 1, 1, "rstmid");
    for (int i = 0; i < 5; i++) step(0, 1, 0, "rstmid");
    step(1, 1, 0, "rstmid");
    check("rst_outs", outs(), 4'b0000);
    for (int i = 0; i < 15; i++) step(0, 1, 0, "rstmid");
    check("rst_quiet", {n_s[1:0], n_d[1:0]} | {2'b0, n_l[1:0]} | {3'b0, busy}, 4'b0000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, "rstmid");

    // ---- triple press: third flag lands while second press is held ----
    idle_n(2);
    step(0, 1, 1, "tri"); step(0, 1, 0, "tri");
    step(0, 0, 0, "tri"); step(0, 0, 0, "tri");
    step(0, 1, 1, "tri");
    check("tri_double", outs(), 4'b0101);
    step(0, 1, 0, "tri");
    step(0, 1, 1, "tri");
    step(0, 1, 0, "tri");
    for (int i = 0; i < 10; i++) step(0, 0, 0, "tri");
    check("tri_counts", {n_s[1:0], n_d[1:0]} | {2'b0, n_l[1:0]}, 4'b0001);

    // ---- randomized against the model ----
    begin
      logic b, pb, f, r;
      int   run;
      b = 1'b0; pb = 1'b0; run = 0;
      for (int i = 0; i < 2000; i++) begin
        if (run == 0) begin
          b   = ~b;
          run = int'($urandom_range(1, 12));
        end
        run--;
        f = (b && !pb) ? 1'b1 : ($urandom_range(0, 19) == 0);
        r = ($urandom_range(0, 99) == 0);
        step(r, b, f, "rand");
        pb = b;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 Parameter LONG_CYC, default 200, is the number of held cycles after a confirmed press that classifies it as a long press.
REQ-002 Parameter GAP_CYC, default 150, is the maximum number of released cycles allowed between the two presses of a double press.
REQ-003 Parameter CNT_W, default 10, is the width of the internal cycle counter.
REQ-004 Port clk_d, input, 1 bit: the single block clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port bt, input, 1 bit: stable button level from the debounce stage; 1 means pressed.
REQ-007 Port bt_flag, input, 1 bit: one-cycle pulse from the debounce stage marking a confirmed press.
REQ-008 Port single_p, output, 1 bit: one-cycle pulse marking a completed single short press.
REQ-009 Port double_p, output, 1 bit: one-cycle pulse marking a double press.
REQ-010 Port long_p, output, 1 bit: one-cycle pulse marking a long press.
REQ-011 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 The state machine SHALL have exactly five states: IDLE, HELD1, GAP, HELD2 and REL.
REQ-013 IDLE: bt_flag=1 -> HELD1, counter cleared to 0; all other inputs ignored.
REQ-014 HELD1 with bt=1: the counter increments each cycle.
REQ-015 HELD1 when the counter equals LONG_CYC-1 with bt=1: assert long_p for one cycle and go to REL.
REQ-016 HELD1 with bt=0: go to GAP with the counter cleared; bt_flag is ignored in HELD1.
REQ-017 GAP with bt_flag=1: assert double_p for one cycle and go to HELD2.
REQ-018 GAP with no bt_flag: the counter increments; when it equals GAP_CYC-1, assert single_p for one cycle and go to IDLE.
REQ-019 GAP with bt_flag=1 on the same cycle the counter reaches GAP_CYC-1: double_p wins and single_p is not asserted.
REQ-020 HELD2 and REL: wait for bt=0, then go to IDLE; bt_flag is ignored in both states, so a third press is never classified.
REQ-021 single_p, double_p and long_p SHALL be registered, asserted in the cycle after the deciding edge, and mutually exclusive.
REQ-022 At most one classification pulse SHALL be produced per press sequence.
REQ-023 The counter SHALL never wrap; CNT_W SHALL satisfy 2^CNT_W > max(LONG_CYC, GAP_CYC).
REQ-024 busy SHALL be a registered decode of the state.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, counter=0, single_p=double_p=long_p=busy=0.
REQ-026 rst SHALL override every input, including a bt_flag in the same cycle.
REQ-027 Reset in mid-sequence SHALL discard the partial classification and produce no pulse.
REQ-028 After reset is released, a press still held (bt=1) without a new bt_flag SHALL be ignored.

Structure
REQ-029 The state enumeration and the LONG_CYC/GAP_CYC defaults SHALL live in the shared button package, alongside the debounce stage constants.
REQ-030 The block SHALL be a single module with no sub-modules; the counter is inline.
REQ-031 The block connects directly downstream of the debounce flag stage on the same clk_d and rst.

Verification (LONG_CYC=8, GAP_CYC=6)
REQ-032 Single press: bt_flag pulse, bt high 3 cycles, then low -> single_p exactly once, 6 cycles after release; busy falls with it.
REQ-033 Long press: bt_flag pulse, bt held 20 cycles -> long_p exactly once, 8 cycles after bt_flag; busy stays high until release plus 1 cycle.
REQ-034 Double press: press 2 cycles, release 3 cycles, second bt_flag -> double_p one cycle later; no single_p.
REQ-035 Gap boundary: second bt_flag on the 6th released cycle -> double_p only; second bt_flag on the 7th released cycle -> single_p, then a new sequence starts.
REQ-036 Reset: rst asserted in HELD1 at count 5 -> all outputs 0 the next cycle and no pulse afterwards, while bt is held with no new flag.
REQ-037 Triple press: three bt_flag pulses within the gap window -> exactly one double_p, with no pulse for the third press.
